// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the IF/MEM memory arbiter: FSM state codes, owner codes
// and the access-cycle counter type.
package mem_arbiter_pkg;

   localparam logic [1:0] ARB_IDLE   = 2'd0;
   localparam logic [1:0] ARB_ACCESS = 2'd1;
   localparam logic [1:0] ARB_DONE   = 2'd2;

   localparam logic ARB_OWN_IF = 1'b0;
   localparam logic ARB_OWN_DM = 1'b1;

   // Wide enough for LATENCY-1 with LATENCY up to 15.
   typedef logic [3:0] lat_cnt_t;

   function automatic logic last_beat(input lat_cnt_t cnt, input int unsigned latency);
      return cnt == lat_cnt_t'(latency - 1);
   endfunction

endpackage

// File: rtl/mem_arbiter_arb_select.sv
// Winner selection for the shared memory: data port has priority, but a run of
// STARVE_LIMIT data grants while a fetch is waiting forces the next grant to IF.
module arb_select #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic if_req,
   input  logic dm_req,
   input  logic if_flush,
   input  logic grant_en,
   output logic grant_if,
   output logic grant_dm
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   logic [SW-1:0] starve_cnt;
   logic          force_if;

   assign force_if = if_req && (starve_cnt == LIMIT);
   assign grant_dm = grant_en && dm_req && !force_if;
   assign grant_if = grant_en && !grant_dm && if_req && !if_flush;

   // Counts data grants that overtook a waiting fetch; saturates at the limit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (grant_if) begin
         starve_cnt <= '0;
      end else if (grant_dm && if_req && (starve_cnt != LIMIT)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and the
// load/store stage, sequencing each access over LATENCY cycles.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int LATENCY      = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_stall,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_ack,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_stall,
   output logic              mem_cs,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   logic [1:0] state;
   logic       owner;
   logic       acc_we;
   logic       flush_pend;
   logic       if_ack_q;
   lat_cnt_t   cnt;
   logic       grant_if;
   logic       grant_dm;

   arb_select #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_select (
      .clk      (clk),
      .rst      (rst),
      .if_req   (if_req),
      .dm_req   (dm_req),
      .if_flush (if_flush),
      .grant_en (state == ARB_IDLE),
      .grant_if (grant_if),
      .grant_dm (grant_dm)
   );

   // mem_addr/mem_wdata double as the latched request; mem_we only spans the first access cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ARB_IDLE;
         owner      <= ARB_OWN_IF;
         acc_we     <= 1'b0;
         flush_pend <= 1'b0;
         if_ack_q   <= 1'b0;
         dm_ack     <= 1'b0;
         cnt        <= '0;
         mem_cs     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         if_rdata   <= '0;
         dm_rdata   <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               flush_pend <= 1'b0;
               cnt        <= '0;
               if (grant_dm) begin
                  owner     <= ARB_OWN_DM;
                  acc_we    <= dm_we;
                  mem_cs    <= 1'b1;
                  mem_we    <= dm_we;
                  mem_addr  <= dm_addr;
                  mem_wdata <= dm_wdata;
                  state     <= ARB_ACCESS;
               end else if (grant_if) begin
                  owner     <= ARB_OWN_IF;
                  acc_we    <= 1'b0;
                  mem_cs    <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= if_addr;
                  mem_wdata <= '0;
                  state     <= ARB_ACCESS;
               end
            end
            ARB_ACCESS: begin
               mem_we <= 1'b0;
               cnt    <= cnt + 1'b1;
               if ((owner == ARB_OWN_IF) && if_flush) begin
                  flush_pend <= 1'b1;
               end
               if (last_beat(cnt, LATENCY)) begin
                  mem_cs <= 1'b0;
                  state  <= ARB_DONE;
                  if (owner == ARB_OWN_DM) begin
                     dm_ack <= 1'b1;
                     if (!acc_we) begin
                        dm_rdata <= mem_rdata;
                     end
                  end else if (!flush_pend && !if_flush) begin
                     if_ack_q <= 1'b1;
                     if_rdata <= mem_rdata;
                  end
               end
            end
            ARB_DONE: begin
               if_ack_q <= 1'b0;
               dm_ack   <= 1'b0;
               state    <= ARB_IDLE;
            end
            default: begin
               state <= ARB_IDLE;
            end
         endcase
      end
   end

   // A flush arriving in the ack cycle still cancels the fetch from the pipeline's view.
   assign if_ack   = if_ack_q & ~if_flush;
   assign if_stall = if_req & ~if_ack;
   assign dm_stall = dm_req & ~dm_ack;
   assign busy     = (state != ARB_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised self-checking bench for mem_arbiter against a grant-order/latency
// model and a shadow copy of the memory contents.
module tb_mem_arbiter;

   localparam int LAT    = 2;
   localparam int STARVE = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req = 1'b0, if_flush = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
   logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
   logic        if_ack, if_stall, dm_ack, dm_stall, mem_cs, mem_we, busy;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Environment memory (what the arbiter talks to) and the bench's own shadow copy.
   logic [31:0] env_mem [256];
   bit          env_valid [256];
   logic [31:0] ref_mem [256];
   bit          ref_valid [256];
   int          starve_m = 0;
   logic [31:0] last_if_d = '0;
   logic [31:0] last_dm_d = '0;

   typedef struct {
      int          start, if_cyc, dm_cyc, if_stall_n, we_n, cs_n, cs_first, spur;
      logic [31:0] if_d, dm_d, we_data, we_addr;
   } res_t;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT), .STARVE_LIMIT(STARVE)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] seed(input logic [7:0] w);
      if (w == 8'd16) return 32'h8C01_0004;
      return {w, ~w, w ^ 8'h5A, 8'hC3};
   endfunction

   always_comb begin
      mem_rdata = '0;
      if (mem_cs)
         mem_rdata = env_valid[mem_addr[9:2]] ? env_mem[mem_addr[9:2]] : seed(mem_addr[9:2]);
   end

   always @(posedge clk) begin
      if (mem_cs && mem_we) begin
         env_mem[mem_addr[9:2]]   <= mem_wdata;
         env_valid[mem_addr[9:2]] <= 1'b1;
      end
   end

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      return ref_valid[a[9:2]] ? ref_mem[a[9:2]] : seed(a[9:2]);
   endfunction

   // Model: who is served first, when each ack lands (cycles after request), and what data it carries.
   function automatic void predict(input bit do_if, input bit do_dm, input logic [31:0] ia,
                                   input bit we, input logic [31:0] da, input logic [31:0] wd,
                                   output int if_off, output int dm_off,
                                   output logic [31:0] eif, output logic [31:0] edm);
      int  first  = LAT + 1;
      int  second = 2 * LAT + 3;
      bit  if_first;
      if_off = -1;
      dm_off = -1;
      eif    = last_if_d;
      edm    = last_dm_d;
      if_first = do_if && (!do_dm || starve_m == STARVE);
      if (if_first) begin
         if_off   = first;
         eif      = ref_read(ia);
         starve_m = 0;
      end
      if (do_dm) begin
         dm_off = if_first ? second : first;
         if (!if_first && do_if) starve_m = (starve_m < STARVE) ? starve_m + 1 : starve_m;
         if (we) begin
            ref_mem[da[9:2]]   = wd;
            ref_valid[da[9:2]] = 1'b1;
         end else begin
            edm = ref_read(da);
         end
      end
      if (do_if && !if_first) begin
         if_off   = second;
         eif      = ref_read(ia);
         starve_m = 0;
      end
      last_if_d = eif;
      last_dm_d = edm;
   endfunction

   // Drives one or two simultaneous requests and records what the DUT did, dropping each req on its ack.
   task automatic run_pair(input bit do_if, input bit do_dm, input logic [31:0] ia, input bit we,
                           input logic [31:0] da, input logic [31:0] wd, output res_t r);
      @(negedge clk);
      r.start = cyc; r.if_cyc = -1; r.dm_cyc = -1; r.if_stall_n = 0; r.we_n = 0;
      r.cs_n = 0; r.cs_first = -1; r.spur = 0;
      r.if_d = '0; r.dm_d = '0; r.we_data = '0; r.we_addr = '0;
      if_req = do_if; if_addr = ia;
      dm_req = do_dm; dm_we = we; dm_addr = da; dm_wdata = wd;
      for (int k = 0; k < 60 && (if_req || dm_req); k++) begin
         #1;
         if (if_stall) r.if_stall_n++;
         if (mem_cs) begin
            r.cs_n++;
            if (r.cs_first < 0) r.cs_first = cyc;
         end
         if (mem_we) begin
            r.we_n++;
            r.we_data = mem_wdata;
            r.we_addr = mem_addr;
         end
         if ((if_ack && !if_req) || (dm_ack && !dm_req)) r.spur++;
         if (if_req && if_ack) begin
            r.if_cyc = cyc; r.if_d = if_rdata; if_req = 1'b0;
         end
         if (dm_req && dm_ack) begin
            r.dm_cyc = cyc; r.dm_d = dm_rdata; dm_req = 1'b0;
         end
         @(negedge clk);
      end
      if_req = 1'b0;
      dm_req = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      checks++; if ({mem_cs, mem_we, busy, if_ack, dm_ack, if_stall, dm_stall} !== 7'b0) begin
         errors++; $display("[TB] FAIL reset_flags: got %b expected 0000000",
                            {mem_cs, mem_we, busy, if_ack, dm_ack, if_stall, dm_stall});
      end
      checks++; if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'b0) begin
         errors++; $display("[TB] FAIL reset_regs: addr %h wdata %h if_rdata %h dm_rdata %h expected all 0",
                            mem_addr, mem_wdata, if_rdata, dm_rdata);
      end
      rst = 1'b1;
   endtask

   task automatic test_lone_fetch();
      res_t r; int io, dof; logic [31:0] eif, edm;
      predict(1, 0, 32'h40, 0, 0, 0, io, dof, eif, edm);
      run_pair(1, 0, 32'h40, 0, 0, 0, r);
      checks++; if (r.if_cyc !== r.start + io) begin
         errors++; $display("[TB] FAIL lone_ack_cycle: got %0d expected %0d", r.if_cyc, r.start + io);
      end
      checks++; if (r.if_d !== 32'h8C01_0004) begin
         errors++; $display("[TB] FAIL lone_rdata: got %h expected 8c010004", r.if_d);
      end
      checks++; if (r.cs_first !== r.start + 1 || r.cs_n !== LAT) begin
         errors++; $display("[TB] FAIL lone_cs_window: first %0d count %0d expected %0d %0d",
                            r.cs_first, r.cs_n, r.start + 1, LAT);
      end
      checks++; if (r.we_n !== 0 || r.spur !== 0 || r.if_stall_n !== io) begin
         errors++; $display("[TB] FAIL lone_we_spur_stall: we %0d spur %0d stall %0d expected 0 0 %0d",
                            r.we_n, r.spur, r.if_stall_n, io);
      end
   endtask

   task automatic test_simultaneous();
      res_t r; int io, dof; logic [31:0] eif, edm;
      predict(1, 1, 32'h10, 0, 32'h20, 0, io, dof, eif, edm);
      run_pair(1, 1, 32'h10, 0, 32'h20, 0, r);
      checks++; if (r.dm_cyc !== r.start + dof || r.if_cyc !== r.start + io) begin
         errors++; $display("[TB] FAIL simul_order: dm %0d if %0d expected %0d %0d",
                            r.dm_cyc - r.start, r.if_cyc - r.start, dof, io);
      end
      checks++; if (r.if_d !== eif || r.dm_d !== edm) begin
         errors++; $display("[TB] FAIL simul_data: if %h dm %h expected %h %h", r.if_d, r.dm_d, eif, edm);
      end
      checks++; if (r.if_stall_n !== io) begin
         errors++; $display("[TB] FAIL simul_if_stall: got %0d cycles expected %0d", r.if_stall_n, io);
      end
   endtask

   task automatic test_store_load();
      res_t r; int io, dof; logic [31:0] eif, edm, prev;
      prev = last_dm_d;
      predict(0, 1, 0, 1, 32'h8, 32'hDEAD_BEEF, io, dof, eif, edm);
      run_pair(0, 1, 0, 1, 32'h8, 32'hDEAD_BEEF, r);
      checks++; if (r.we_n !== 1 || r.we_data !== 32'hDEAD_BEEF || r.we_addr !== 32'h8) begin
         errors++; $display("[TB] FAIL store_we: cycles %0d data %h addr %h expected 1 deadbeef 00000008",
                            r.we_n, r.we_data, r.we_addr);
      end
      checks++; if (r.dm_cyc !== r.start + dof || r.dm_d !== prev) begin
         errors++; $display("[TB] FAIL store_ack: cycle %0d rdata %h expected %0d %h",
                            r.dm_cyc, r.dm_d, r.start + dof, prev);
      end
      predict(0, 1, 0, 0, 32'h8, 0, io, dof, eif, edm);
      run_pair(0, 1, 0, 0, 32'h8, 0, r);
      checks++; if (r.dm_d !== 32'hDEAD_BEEF || r.dm_cyc !== r.start + dof) begin
         errors++; $display("[TB] FAIL store_readback: rdata %h cycle %0d expected deadbeef %0d",
                            r.dm_d, r.dm_cyc, r.start + dof);
      end
   endtask

   task automatic test_starvation();
      logic [31:0] ia = 32'h80, da = 32'hC0;
      bit exp_if [10]; bit got_if [10]; int got_cyc [10]; logic [31:0] got_d [10];
      int n = 0; int start;
      for (int g = 0; g < 10; g++) begin
         exp_if[g] = (starve_m == STARVE);
         starve_m  = exp_if[g] ? 0 : ((starve_m < STARVE) ? starve_m + 1 : starve_m);
      end
      @(negedge clk);
      start = cyc;
      if_req = 1'b1; if_addr = ia; dm_req = 1'b1; dm_we = 1'b0; dm_addr = da;
      for (int k = 0; k < 10 * (LAT + 2) + 20 && n < 10; k++) begin
         #1;
         if (if_ack || dm_ack) begin
            got_if[n] = if_ack; got_cyc[n] = cyc; got_d[n] = if_ack ? if_rdata : dm_rdata;
            n++;
            if (n == 10) begin
               if_req = 1'b0; dm_req = 1'b0;
            end
         end
         @(negedge clk);
      end
      if_req = 1'b0; dm_req = 1'b0;
      checks++; if (n !== 10) begin
         errors++; $display("[TB] FAIL starve_count: got %0d acks expected 10", n);
      end
      for (int g = 0; g < n; g++) begin
         checks++; if (got_if[g] !== exp_if[g] || got_cyc[g] !== start + LAT + 1 + g * (LAT + 2)) begin
            errors++; $display("[TB] FAIL starve_grant%0d: is_if %0d cycle %0d expected %0d %0d", g,
                               got_if[g], got_cyc[g] - start, exp_if[g], LAT + 1 + g * (LAT + 2));
         end
         checks++; if (got_d[g] !== ref_read(got_if[g] ? ia : da)) begin
            errors++; $display("[TB] FAIL starve_data%0d: got %h expected %h", g, got_d[g],
                               ref_read(got_if[g] ? ia : da));
         end
      end
      last_if_d = ref_read(ia);
      last_dm_d = ref_read(da);
   endtask

   task automatic test_flush();
      res_t r; int io, dof, c, acks = 0, cs_n = 0; logic [31:0] eif, edm, prev;
      logic busy_done = 1'b0, busy_idle = 1'b1;
      prev = last_if_d;
      @(negedge clk);
      c = cyc;
      if_req = 1'b1; if_addr = 32'h44;
      starve_m = 0;
      for (int k = 1; k <= LAT + 4; k++) begin
         @(negedge clk); #1;
         if (if_ack) acks++;
         if (mem_cs) cs_n++;
         if (cyc == c + LAT) if_flush = 1'b1;
         if (cyc == c + LAT + 1) begin
            busy_done = busy; if_flush = 1'b0; if_req = 1'b0;
         end
         if (cyc == c + LAT + 2) busy_idle = busy;
      end
      checks++; if (acks !== 0 || if_rdata !== prev) begin
         errors++; $display("[TB] FAIL flush_suppress: acks %0d if_rdata %h expected 0 %h", acks, if_rdata, prev);
      end
      checks++; if (busy_done !== 1'b1 || busy_idle !== 1'b0 || cs_n !== LAT) begin
         errors++; $display("[TB] FAIL flush_schedule: busy %b/%b cs %0d expected 1/0 %0d",
                            busy_done, busy_idle, cs_n, LAT);
      end
      predict(0, 1, 0, 0, 32'h50, 0, io, dof, eif, edm);
      run_pair(0, 1, 0, 0, 32'h50, 0, r);
      checks++; if (r.dm_cyc !== r.start + dof || r.dm_d !== edm) begin
         errors++; $display("[TB] FAIL flush_then_dm: cycle %0d data %h expected %0d %h",
                            r.dm_cyc - r.start, r.dm_d, dof, edm);
      end
   endtask

   task automatic test_reset_mid_access();
      int acks = 0;
      @(negedge clk);
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h30; dm_wdata = 32'h1234_5678;
      @(negedge clk); #1;
      checks++; if (mem_cs !== 1'b1 || mem_we !== 1'b1) begin
         errors++; $display("[TB] FAIL midrst_pre: cs %b we %b expected 1 1", mem_cs, mem_we);
      end
      rst = 1'b0;
      #1;
      checks++; if (mem_cs !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("[TB] FAIL midrst_abort: cs %b we %b busy %b expected 0 0 0", mem_cs, mem_we, busy);
      end
      dm_req = 1'b0; dm_we = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      starve_m = 0; last_if_d = '0; last_dm_d = '0;
      repeat (LAT + 3) begin
         @(negedge clk); #1;
         if (if_ack || dm_ack) acks++;
      end
      checks++; if (acks !== 0 || dm_rdata !== last_dm_d || if_rdata !== last_if_d) begin
         errors++; $display("[TB] FAIL midrst_after: acks %0d dm_rdata %h if_rdata %h expected 0 0 0",
                            acks, dm_rdata, if_rdata);
      end
   endtask

   task automatic test_random();
      res_t r; int io, dof; logic [31:0] eif, edm, ia, da, wd; bit di, dd, we; int op;
      for (int t = 0; t < 24; t++) begin
         op = $urandom_range(0, 2);
         di = (op != 1); dd = (op != 0);
         ia = 32'($urandom_range(0, 31)) << 2;
         da = 32'($urandom_range(0, 31)) << 2;
         we = 1'($urandom_range(0, 1));
         wd = $urandom;
         predict(di, dd, ia, we, da, wd, io, dof, eif, edm);
         run_pair(di, dd, ia, we, da, wd, r);
         checks++; if (r.if_cyc !== (io < 0 ? -1 : r.start + io) || r.dm_cyc !== (dof < 0 ? -1 : r.start + dof)) begin
            errors++; $display("[TB] FAIL rand%0d_timing: if %0d dm %0d expected offsets %0d %0d", t,
                               r.if_cyc - r.start, r.dm_cyc - r.start, io, dof);
         end
         checks++; if ((di && r.if_d !== eif) || (dd && r.dm_d !== edm) || r.spur !== 0) begin
            errors++; $display("[TB] FAIL rand%0d_data: if %h dm %h spur %0d expected %h %h 0", t,
                               r.if_d, r.dm_d, r.spur, eif, edm);
         end
      end
   endtask

   initial begin
      test_reset();
      test_lone_fetch();
      test_simultaneous();
      test_store_load();
      test_starvation();
      test_flush();
      test_reset_mid_access();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
